alarm_ringer: RTL and testbench
===============================

Name: alarm_ringer

Overview:
- Consumer side of the alarm's `beep` match output: turns the level-high "time equals alarm time" signal into a user-facing ring sequence.
- Drives a gated square-wave buzzer with on/off cadence, and handles stop, snooze and ring timeout.
- Prevents re-triggering within the same matching minute.
- Sits between the alarm comparator and the board buzzer/LED pins, clocked by the system clock.

Parameters:
- TONE_HALF, 25000, clk cycles per buzzer half-period (tone = f_clk / (2*TONE_HALF)).
- BEEP_ON, 25000000, clk cycles of tone per cadence period.
- BEEP_OFF, 25000000, clk cycles of silence per cadence period.
- SNOOZE_CYCLES, 250000000, clk cycles spent silent in SNOOZE before re-ringing.
- RING_TIMEOUT, 3000000000, clk cycles in one RING visit before automatic stop.
- MAX_SNOOZE, 3, snoozes allowed per alarm event (1..15).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- alarm_enable  in  1  level; 0 forces IDLE and silence.
- match  in  1  level from alarm comparator, high while hour/minute equal alarm setting.
- stop_btn  in  1  single-cycle pulse, already debounced.
- snooze_btn  in  1  single-cycle pulse, already debounced.
- buzzer  out  1  gated square wave to the piezo.
- ringing  out  1  high in RING.
- snoozed  out  1  high in SNOOZE.
- snooze_count  out  4  snoozes used in the current event.

Behaviour:
- All outputs are registered. Reset values: buzzer=0, ringing=0, snoozed=0, snooze_count=0, state=IDLE, match_prev=1.
- match_prev is the registered previous match. Because it resets to 1, a match already high out of reset does not ring.
- A rising edge is match==1 && match_prev==0.
- States:
  - IDLE
  - RING
  - SNOOZE
  - DONE (wait for match to drop)
- Transitions, evaluated in priority order:
  - alarm_enable==0 -> IDLE from any state; snooze_count cleared.
  - IDLE: rising edge with alarm_enable=1 -> RING.
  - RING, stop_btn -> DONE.
  - RING, snooze_btn with snooze_count<MAX_SNOOZE -> SNOOZE, snooze_count+1.
  - RING, snooze_btn with snooze_count==MAX_SNOOZE -> treated as stop -> DONE.
  - RING, ring counter reaches RING_TIMEOUT-1 -> DONE.
  - SNOOZE, stop_btn -> DONE.
  - SNOOZE, snooze_btn -> ignored.
  - SNOOZE, counter reaches SNOOZE_CYCLES-1 -> RING, regardless of match.
  - DONE: match==0 -> IDLE with snooze_count cleared; otherwise hold.
  - stop and snooze pulses in the same cycle: stop wins.
- Latency: rising edge sampled at edge N -> ringing=1 after edge N+1.
- Entry to RING (initial or from SNOOZE):
  - ring, cadence and tone counters clear to 0.
  - cadence starts in ON phase.
  - tone phase starts at 0.
- Cadence:
  - ON phase lasts BEEP_ON cycles, then OFF phase BEEP_OFF cycles, repeating.
  - The tone phase register toggles every TONE_HALF cycles while ON.
  - Tone phase is held at 0 and the tone counter is cleared while OFF, so each ON burst starts low.
- buzzer = tone phase AND ON phase AND state==RING. It is registered, so buzzer is 0 in every other state.
- Counter widths: each sized by $clog2 of its parameter. Counters wrap only through the explicit compare, never by overflow.
- Counters never run outside their state. The SNOOZE counter clears on entry to SNOOZE.
- Reset mid-ring: next edge gives all outputs at reset values. A still-high match does not re-ring because match_prev reset is 1.
- match dropping during RING or SNOOZE does not end ringing; only stop, timeout or disable do.

Test Plan:
All scenarios use TONE_HALF=2, BEEP_ON=8, BEEP_OFF=8, SNOOZE_CYCLES=20, RING_TIMEOUT=64, MAX_SNOOZE=2.
- Basic ring: enable=1, match rises at cycle 10 -> ringing=1 from cycle 12.
  - buzzer pattern is 0,0,1,1,0,0,1,1 for 8 cycles, then 0 for 8 cycles, repeating.
  - ringing=0 and state DONE 64 cycles after entry.
  - match low -> IDLE.
- Stop with match still high: stop_btn pulse 5 cycles into RING -> ringing=0 next cycle and buzzer=0.
  - Holding match high 100 cycles gives no re-ring.
  - match low then high -> rings again.
- Snooze limit:
  - First snooze_btn -> snoozed=1, snooze_count=1; RING re-entered after 20 cycles.
  - Second snooze -> count=2.
  - Third snooze_btn -> DONE, snooze_count stays 2 until match low.
- Simultaneous stop_btn and snooze_btn in RING -> DONE, snooze_count unchanged.
- Disable: alarm_enable=0 during SNOOZE -> IDLE next cycle, snoozed=0, snooze_count=0.
  - Re-enable with match high -> no ring until a new rising edge.
- Reset: rst pulse during RING with match high -> all outputs 0 the cycle after.
  - No ring while match stays high; power-up with match=1 gives no ring.

Source files
------------

// File: rtl/alarm_ringer.sv
// Alarm ring sequencer: converts the level-high alarm match into a cadenced,
// gated buzzer tone with stop, limited snooze and automatic ring timeout.
module alarm_ringer #(
   parameter longint unsigned TONE_HALF     = 64'd25000,
   parameter longint unsigned BEEP_ON       = 64'd25000000,
   parameter longint unsigned BEEP_OFF      = 64'd25000000,
   parameter longint unsigned SNOOZE_CYCLES = 64'd250000000,
   parameter longint unsigned RING_TIMEOUT  = 64'd3000000000,
   parameter int unsigned     MAX_SNOOZE    = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       alarm_enable,
   input  logic       match,
   input  logic       stop_btn,
   input  logic       snooze_btn,
   output logic       buzzer,
   output logic       ringing,
   output logic       snoozed,
   output logic [3:0] snooze_count
);

   localparam longint unsigned CAD_MAX = (BEEP_ON > BEEP_OFF) ? BEEP_ON : BEEP_OFF;

   localparam int TW = (TONE_HALF     > 64'd1) ? $clog2(TONE_HALF)     : 1;
   localparam int CW = (CAD_MAX       > 64'd1) ? $clog2(CAD_MAX)       : 1;
   localparam int SW = (SNOOZE_CYCLES > 64'd1) ? $clog2(SNOOZE_CYCLES) : 1;
   localparam int RW = (RING_TIMEOUT  > 64'd1) ? $clog2(RING_TIMEOUT)  : 1;

   localparam logic [TW-1:0] TONE_LAST = TW'(TONE_HALF - 64'd1);
   localparam logic [CW-1:0] ON_LAST   = CW'(BEEP_ON - 64'd1);
   localparam logic [CW-1:0] OFF_LAST  = CW'(BEEP_OFF - 64'd1);
   localparam logic [SW-1:0] SNZ_LAST  = SW'(SNOOZE_CYCLES - 64'd1);
   localparam logic [RW-1:0] RING_LAST = RW'(RING_TIMEOUT - 64'd1);
   localparam logic [3:0]    SNZ_LIMIT = 4'(MAX_SNOOZE);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RING   = 2'd1,
      S_SNOOZE = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t        state, state_nxt;
   logic          match_prev;
   logic          rise;
   logic [3:0]    count_nxt;

   logic [RW-1:0] ring_cnt, ring_nxt;
   logic [SW-1:0] snz_cnt, snz_nxt;
   logic [CW-1:0] cad_cnt, cad_nxt;
   logic          cad_on, cad_on_nxt;
   logic [TW-1:0] tone_cnt, tone_nxt;
   logic          tone_ph, tone_ph_nxt;
   logic          stay_ring, stay_snz;

   logic          buzzer_nxt, ringing_nxt, snoozed_nxt;

   assign rise = match & ~match_prev;

   // match_prev resets high so a match already present at reset never rings
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         match_prev   <= 1'b1;
         snooze_count <= '0;
         ring_cnt     <= '0;
         snz_cnt      <= '0;
         cad_cnt      <= '0;
         cad_on       <= 1'b1;
         tone_cnt     <= '0;
         tone_ph      <= 1'b0;
         buzzer       <= 1'b0;
         ringing      <= 1'b0;
         snoozed      <= 1'b0;
      end else begin
         state        <= state_nxt;
         match_prev   <= match;
         snooze_count <= count_nxt;
         ring_cnt     <= ring_nxt;
         snz_cnt      <= snz_nxt;
         cad_cnt      <= cad_nxt;
         cad_on       <= cad_on_nxt;
         tone_cnt     <= tone_nxt;
         tone_ph      <= tone_ph_nxt;
         buzzer       <= buzzer_nxt;
         ringing      <= ringing_nxt;
         snoozed      <= snoozed_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      count_nxt = snooze_count;
      if (!alarm_enable) begin
         state_nxt = S_IDLE;
         count_nxt = '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (rise) state_nxt = S_RING;
            end
            S_RING: begin
               if (stop_btn) begin
                  state_nxt = S_DONE;
               end else if (snooze_btn) begin
                  // once the snooze budget is spent a snooze press acts as stop
                  if (snooze_count < SNZ_LIMIT) begin
                     state_nxt = S_SNOOZE;
                     count_nxt = snooze_count + 4'd1;
                  end else begin
                     state_nxt = S_DONE;
                  end
               end else if (ring_cnt == RING_LAST) begin
                  state_nxt = S_DONE;
               end
            end
            S_SNOOZE: begin
               if (stop_btn)                  state_nxt = S_DONE;
               else if (snz_cnt == SNZ_LAST)  state_nxt = S_RING;
            end
            S_DONE: begin
               if (!match) begin
                  state_nxt = S_IDLE;
                  count_nxt = '0;
               end
            end
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   // counters run only while the state persists, so any entry starts them at 0
   always_comb begin
      stay_ring   = (state == S_RING)   && (state_nxt == S_RING);
      stay_snz    = (state == S_SNOOZE) && (state_nxt == S_SNOOZE);
      ring_nxt    = stay_ring ? ring_cnt + 1'b1 : '0;
      snz_nxt     = stay_snz  ? snz_cnt  + 1'b1 : '0;
      cad_nxt     = '0;
      cad_on_nxt  = 1'b1;
      tone_nxt    = '0;
      tone_ph_nxt = 1'b0;
      if (stay_ring) begin
         if (cad_on) begin
            if (cad_cnt == ON_LAST) begin
               cad_on_nxt = 1'b0;
            end else begin
               cad_nxt = cad_cnt + 1'b1;
               if (tone_cnt == TONE_LAST) begin
                  tone_ph_nxt = ~tone_ph;
               end else begin
                  tone_nxt    = tone_cnt + 1'b1;
                  tone_ph_nxt = tone_ph;
               end
            end
         end else begin
            // silent phase keeps the tone parked low so each burst starts low
            if (cad_cnt == OFF_LAST) begin
               cad_on_nxt = 1'b1;
            end else begin
               cad_on_nxt = 1'b0;
               cad_nxt    = cad_cnt + 1'b1;
            end
         end
      end
   end

   always_comb begin
      ringing_nxt = (state == S_RING);
      snoozed_nxt = (state == S_SNOOZE);
      buzzer_nxt  = tone_ph & cad_on & (state == S_RING);
   end

endmodule

// File: tb/tb_alarm_ringer.sv
// Bench for alarm_ringer: vector table, directed corner sequences and a
// randomized run checked against a time-since-entry reference model.
module tb_alarm_ringer;

   localparam int T_HALF = 2;
   localparam int B_ON   = 8;
   localparam int B_OFF  = 8;
   localparam int SNZ_C  = 20;
   localparam int RING_T = 64;
   localparam int MAXS   = 2;

   logic       clk;
   logic       rst;
   logic       alarm_enable;
   logic       match;
   logic       stop_btn;
   logic       snooze_btn;
   logic       buzzer;
   logic       ringing;
   logic       snoozed;
   logic [3:0] snooze_count;

   int n_pass = 0;
   int n_tot  = 0;

   alarm_ringer #(
      .TONE_HALF(T_HALF), .BEEP_ON(B_ON), .BEEP_OFF(B_OFF),
      .SNOOZE_CYCLES(SNZ_C), .RING_TIMEOUT(RING_T), .MAX_SNOOZE(MAXS)
   ) dut (
      .clk(clk), .rst(rst), .alarm_enable(alarm_enable), .match(match),
      .stop_btn(stop_btn), .snooze_btn(snooze_btn), .buzzer(buzzer),
      .ringing(ringing), .snoozed(snoozed), .snooze_count(snooze_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #600000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1);
   end

   // reference model: state plus cycles spent in the current visit
   localparam int M_IDLE = 0, M_RING = 1, M_SNZ = 2, M_DONE = 3;
   int         m_st, m_t, m_nst;
   bit         m_prev;
   logic       e_buz, e_ring, e_snz;
   logic [3:0] e_cnt;

   function automatic bit tone_at(input int t);
      int p;
      p = t % (B_ON + B_OFF);
      return (p < B_ON) && (((p / T_HALF) % 2) == 1);
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_st = M_IDLE; m_t = 0; m_prev = 1'b1;
         e_buz = 1'b0; e_ring = 1'b0; e_snz = 1'b0; e_cnt = 4'd0;
      end else begin
         e_ring = (m_st == M_RING);
         e_snz  = (m_st == M_SNZ);
         e_buz  = (m_st == M_RING) && tone_at(m_t);
         m_nst  = m_st;
         if (!alarm_enable) begin
            m_nst = M_IDLE; e_cnt = 4'd0;
         end else if (m_st == M_IDLE) begin
            if (match && !m_prev) m_nst = M_RING;
         end else if (m_st == M_RING) begin
            if (stop_btn) m_nst = M_DONE;
            else if (snooze_btn) begin
               if (e_cnt < MAXS) begin m_nst = M_SNZ; e_cnt = e_cnt + 4'd1; end
               else m_nst = M_DONE;
            end else if (m_t == RING_T - 1) m_nst = M_DONE;
         end else if (m_st == M_SNZ) begin
            if (stop_btn) m_nst = M_DONE;
            else if (m_t == SNZ_C - 1) m_nst = M_RING;
         end else begin
            if (!match) begin m_nst = M_IDLE; e_cnt = 4'd0; end
         end
         m_t    = (m_nst == m_st) ? m_t + 1 : 0;
         m_st   = m_nst;
         m_prev = match;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // one clock: inputs set before the call are sampled at the edge, pulses drop after
   task automatic cyc();
      @(negedge clk);
      stop_btn   = 1'b0;
      snooze_btn = 1'b0;
   endtask

   function automatic logic [31:0] outs();
      return 32'({buzzer, ringing, snoozed, snooze_count});
   endfunction

   typedef struct {
      logic       en, m, stop, snz;
      logic       ring, snzd, buz;
      logic [3:0] cnt;
   } vec_t;

   vec_t       tbl [21];
   logic [15:0] pat;

   initial begin
      tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
      tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
      tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
      tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
      tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0};
      tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0};
      tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
      tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
      tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
      tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
      tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
      tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
      tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1};
      tbl[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1};
      tbl[14] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd1};
      tbl[15] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1};
      tbl[16] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1};
      tbl[17] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
      tbl[18] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
      tbl[19] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
      tbl[20] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
      pat = 16'b0000_0000_1100_1100;

      // power-up with match already high
      rst = 1'b1; alarm_enable = 1'b1; match = 1'b1; stop_btn = 1'b0; snooze_btn = 1'b0;
      cyc(); cyc();
      chk("reset_outputs", outs(), 32'd0);
      rst = 1'b0;
      repeat (5) begin cyc(); chk("powerup_no_ring", 32'(ringing), 32'd0); end

      foreach (tbl[i]) begin
         alarm_enable = tbl[i].en; match = tbl[i].m;
         stop_btn = tbl[i].stop; snooze_btn = tbl[i].snz;
         cyc();
         chk($sformatf("vec%0d", i), outs(),
             32'({tbl[i].buz, tbl[i].ring, tbl[i].snzd, tbl[i].cnt}));
      end

      // full cadence and timeout, then hold match: no re-ring
      match = 1'b0; cyc();
      match = 1'b1; cyc();
      for (int k = 0; k < RING_T; k++) begin
         cyc();
         chk($sformatf("cadence_t%0d", k), 32'({buzzer, ringing}), 32'({pat[k % 16], 1'b1}));
      end
      cyc(); chk("timeout_ringing", 32'(ringing), 32'd0);
      repeat (100) begin cyc(); chk("held_match_no_ring", 32'(ringing | buzzer), 32'd0); end
      match = 1'b0; cyc();

      // snooze limit; match dropping during snooze must not cancel the re-ring
      match = 1'b1; cyc(); cyc();
      snooze_btn = 1'b1; cyc(); chk("snooze1_count", 32'(snooze_count), 32'd1);
      match = 1'b0; cyc(); chk("snooze1_snoozed", 32'(snoozed), 32'd1);
      repeat (19) cyc();
      chk("snooze1_still", 32'({ringing, snoozed}), 32'b01);
      cyc(); chk("snooze1_rering", 32'({ringing, snoozed}), 32'b10);
      match = 1'b1;
      snooze_btn = 1'b1; cyc(); chk("snooze2_count", 32'(snooze_count), 32'd2);
      repeat (20) cyc();
      cyc(); chk("snooze2_rering", 32'({ringing, snoozed}), 32'b10);
      snooze_btn = 1'b1; cyc(); chk("snooze3_count", 32'(snooze_count), 32'd2);
      cyc(); chk("snooze3_done", 32'({ringing, snoozed, snooze_count}), 32'({2'b00, 4'd2}));
      repeat (5) cyc();
      chk("done_hold_count", 32'(snooze_count), 32'd2);
      match = 1'b0; cyc(); chk("done_clear_count", 32'(snooze_count), 32'd0);

      // stop and snooze together in RING: stop wins
      match = 1'b1; cyc(); cyc();
      snooze_btn = 1'b1; cyc();
      repeat (20) cyc();
      stop_btn = 1'b1; snooze_btn = 1'b1; cyc();
      chk("both_btn_count", 32'(snooze_count), 32'd1);
      cyc(); chk("both_btn_done", 32'({ringing, snoozed, snooze_count}), 32'({2'b00, 4'd1}));

      // disable during snooze, re-enable with match high
      match = 1'b0; cyc();
      match = 1'b1; cyc(); cyc();
      snooze_btn = 1'b1; cyc();
      cyc(); chk("dis_in_snooze", 32'(snoozed), 32'd1);
      alarm_enable = 1'b0; cyc(); chk("dis_count", 32'(snooze_count), 32'd0);
      cyc(); chk("dis_outputs", outs(), 32'd0);
      alarm_enable = 1'b1;
      repeat (5) begin cyc(); chk("reenable_no_ring", 32'(ringing), 32'd0); end
      match = 1'b0; cyc();
      match = 1'b1; cyc(); cyc(); chk("new_edge_rings", 32'(ringing), 32'd1);

      // reset mid-ring with match high
      repeat (3) cyc();
      rst = 1'b1; cyc(); chk("rst_mid_ring", outs(), 32'd0);
      rst = 1'b0;
      repeat (5) begin cyc(); chk("rst_no_rering", 32'(ringing), 32'd0); end

      // randomized run against the reference model
      rst = 1'b1; cyc(); rst = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         rst          = ($urandom_range(0, 499) == 0);
         alarm_enable = ($urandom_range(0, 29) != 0);
         if ($urandom_range(0, 24) == 0) match = ~match;
         stop_btn     = ($urandom_range(0, 59) == 0);
         snooze_btn   = ($urandom_range(0, 11) == 0);
         cyc();
         chk($sformatf("rand%0d", n), outs(), 32'({e_buz, e_ring, e_snz, e_cnt}));
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
